lc3_mem_responder: RTL

Memory-side responder for the LC-3 pipeline's instruction and data memory interfaces. The core is the initiator: it drives fetch and data requests (`pc`/`I_macc`/`instrmem_rd`, `Data_addr`/`D_macc`/`Data_rd`/`Data_din`). This block serves those requests from a shared word-addressed array with programmable per-port latency, and signals completion with `complete_instr`/`complete_data`. It replaces the testbench memory behind the core in simulation and doubles as the on-chip RAM stub for synthesis trials. A backdoor load port preloads programs.

---
 rtl/lc3_mem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - LC-3 fetch/data memory responder with per-port latency and backdoor load
module lc3_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int I_LATENCY = 1,
  parameter int D_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        I_macc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic [15:0] Data_addr,
  input  logic        D_macc,
  input  logic        Data_rd,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] I_LOAD = 4'(I_LATENCY - 1);
  localparam logic [3:0] D_LOAD = 4'(D_LATENCY - 1);

  logic [15:0] mem [2**ADDR_BITS];

  state_t                 i_state, i_next, d_state, d_next;
  logic [3:0]             i_cnt, i_cnt_next, d_cnt, d_cnt_next;
  logic [ADDR_BITS-1:0]   i_addr, d_addr, i_rd_addr, d_eff_addr;
  logic                   d_rd, d_eff_rd;
  logic [15:0]            d_din, d_eff_din;
  logic                   i_req, d_req, i_fill, d_fill, d_commit;
  logic                   unused_upper;

  assign i_req        = I_macc & instrmem_rd;
  assign d_req        = D_macc;
  assign unused_upper = ^{pc, Data_addr, load_addr};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_state <= S_IDLE;
      i_cnt   <= 4'd0;
      d_state <= S_IDLE;
      d_cnt   <= 4'd0;
    end else begin
      i_state <= i_next;
      i_cnt   <= i_cnt_next;
      d_state <= d_next;
      d_cnt   <= d_cnt_next;
    end
  end

  always_comb begin
    i_next     = i_state;
    i_cnt_next = i_cnt;
    case (i_state)
      S_IDLE: if (i_req) begin
        i_cnt_next = I_LOAD;
        i_next     = (I_LATENCY > 1) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        i_cnt_next = i_cnt - 4'd1;
        if (i_cnt == 4'd1) i_next = S_DONE;
      end
      default: i_next = S_IDLE;
    endcase
  end

  always_comb begin
    d_next     = d_state;
    d_cnt_next = d_cnt;
    case (d_state)
      S_IDLE: if (d_req) begin
        d_cnt_next = D_LOAD;
        d_next     = (D_LATENCY > 1) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        d_cnt_next = d_cnt - 4'd1;
        if (d_cnt == 4'd1) d_next = S_DONE;
      end
      default: d_next = S_IDLE;
    endcase
  end

  // A single-cycle latency enters DONE on the accepting edge, so the live request bypasses the capture registers.
  always_comb begin
    complete_instr = (i_state == S_DONE);
    complete_data  = (d_state == S_DONE);
    i_fill         = (i_next == S_DONE) && (i_state != S_DONE) && !reset;
    d_fill         = (d_next == S_DONE) && (d_state != S_DONE) && !reset;
    i_rd_addr      = (i_state == S_IDLE) ? pc[ADDR_BITS-1:0] : i_addr;
    d_eff_addr     = (d_state == S_IDLE) ? Data_addr[ADDR_BITS-1:0] : d_addr;
    d_eff_rd       = (d_state == S_IDLE) ? Data_rd : d_rd;
    d_eff_din      = (d_state == S_IDLE) ? Data_din : d_din;
    d_commit       = d_fill && !d_eff_rd;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_addr     <= '0;
      d_addr     <= '0;
      d_rd       <= 1'b0;
      d_din      <= 16'h0000;
      Instr_dout <= 16'h0000;
      Data_dout  <= 16'h0000;
    end else begin
      if (i_state == S_IDLE && i_req) i_addr <= pc[ADDR_BITS-1:0];
      if (d_state == S_IDLE && d_req) begin
        d_addr <= Data_addr[ADDR_BITS-1:0];
        d_rd   <= Data_rd;
        d_din  <= Data_din;
      end
      if (i_fill) Instr_dout <= mem[i_rd_addr];
      if (d_fill && d_eff_rd) Data_dout <= mem[d_eff_addr];
    end
  end

  // The data-port write is last so it overrides a backdoor load to the same word.
  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr[ADDR_BITS-1:0]] <= load_data;
    if (d_commit) mem[d_eff_addr] <= d_eff_din;
  end

endmodule
